// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mdu_pkg                                                    |
// | Purpose : Shared definitions for the multiply/divide unit: operation |
// |           encodings, FSM state encodings and small helper functions. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mdu_pkg;

  // Operation encodings on the 4-bit op bus; 10..15 are reserved.
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Shift-add iterations plus one sign-fixup/accumulate cycle.
  function automatic int mul_cycles(input int width, input int step);
    return width / step + 1;
  endfunction

  // Ops that treat their operands as two's-complement.
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_restoring_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mdu_restoring_div                                          |
// | Purpose : Radix-2 restoring divider on unsigned magnitudes, one      |
// |           quotient bit per cycle.                                    |
// | Ports   : clk, reset      clock / synchronous active-high reset      |
// |           start           load dividend/divisor and begin            |
// |           cancel          abandon the current division               |
// |           dividend,divisor unsigned WIDTH-bit magnitudes             |
// |           quotient,remainder results, meaningful while valid=1       |
// |           valid           high for one cycle after WIDTH steps       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mdu_restoring_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int              C_CNT_W = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH);

  logic               run_q, run_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;

  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_diff;

  assign w_rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, dvs_q};

  assign valid     = run_q && (cnt_q == C_LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      if (cancel || valid) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        // A borrow out of the trial subtraction means the divisor did not fit.
        if (w_diff[WIDTH]) begin
          rem_d = w_rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = w_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_div_unit                                              |
// | Purpose : Iterative multiply/divide unit with HI/LO registers for    |
// |           the EX stage: shift-add multiplier (MUL_STEP bits/cycle),  |
// |           MADD/MSUB accumulate, restoring divider, cancel input.     |
// | Ports   : clk, reset  clock / synchronous active-high reset          |
// |           start, op   issue request and 4-bit operation code         |
// |           a, b        rs / rt operands                               |
// |           cancel      abort in-flight op, drop same-cycle start      |
// |           hi, lo      architectural HI/LO registers                  |
// |           busy        stall request to the hazard unit               |
// |           done        one-cycle pulse after hi/lo commit             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int C_MUL_ITERS = mul_cycles(WIDTH, MUL_STEP) - 1;
  localparam int C_CNT_W     = $clog2(C_MUL_ITERS + 1);
  localparam logic [C_CNT_W-1:0] C_MUL_LAST = C_CNT_W'(C_MUL_ITERS);
  localparam logic [WIDTH-1:0]   C_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------- state ----------------
  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;

  // ---------------- request decode ----------------
  logic             w_accept, w_is_mul_op, w_is_div_op, w_in_signed;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_accept    = start && !cancel && (state_q == ST_IDLE);
  assign w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign w_is_mul_op = (op <= OP_MSUBU) && !w_is_div_op;
  assign w_in_signed = op_is_signed(op);
  assign w_a_mag     = (w_in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag     = (w_in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // ---------------- FSM output decode ----------------
  logic w_running, w_mul_commit, w_div_commit;
  logic w_div_valid;

  always_comb begin
    w_running    = (state_q != ST_IDLE);
    w_mul_commit = (state_q == ST_MUL) && !cancel && (cnt_q == C_MUL_LAST);
    w_div_commit = (state_q == ST_DIV) && !cancel && w_div_valid;
  end

  assign busy = w_running || (start && (op <= OP_MSUBU) && !cancel);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && w_is_mul_op)      state_d = ST_MUL;
        else if (w_accept && w_is_div_op) state_d = ST_DIV;
      end
      ST_MUL:  if (cancel || w_mul_commit) state_d = ST_IDLE;
      ST_DIV:  if (cancel || w_div_commit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- multiplier datapath ----------------
  // Partial product for the low MUL_STEP multiplier bits against the
  // already-shifted multiplicand.
  logic [2*WIDTH-1:0] w_partial;
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) w_partial = w_partial + (mcand_q << i);
    end
  end

  logic               w_mul_neg;
  logic [2*WIDTH-1:0] w_prod_fix, w_hilo, w_mul_result;

  assign w_mul_neg  = op_is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign w_prod_fix = w_mul_neg ? (~prod_q + 1'b1) : prod_q;
  assign w_hilo     = {hi_q, lo_q};

  // Accumulate against hi/lo as they stand at the commit edge.
  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: w_mul_result = w_hilo + w_prod_fix;
      OP_MSUB, OP_MSUBU: w_mul_result = w_hilo - w_prod_fix;
      default:           w_mul_result = w_prod_fix;
    endcase
  end

  // ---------------- divider ----------------
  logic [WIDTH-1:0] w_div_q, w_div_r;

  mdu_restoring_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_accept && w_is_div_op),
    .cancel    (cancel),
    .dividend  (w_a_mag),
    .divisor   (w_b_mag),
    .quotient  (w_div_q),
    .remainder (w_div_r),
    .valid     (w_div_valid)
  );

  logic             w_div_signed, w_q_neg, w_r_neg;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;

  assign w_div_signed = op_is_signed(op_q);
  assign w_r_neg      = w_div_signed && a_q[WIDTH-1];
  assign w_q_neg      = w_div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

  always_comb begin
    if (b_q == '0) begin
      w_div_lo = '1;
      w_div_hi = a_q;
    end else if (w_div_signed && (a_q == C_MIN) && (&b_q)) begin
      w_div_lo = C_MIN;
      w_div_hi = '0;
    end else begin
      w_div_lo = w_q_neg ? (~w_div_q + 1'b1) : w_div_q;
      w_div_hi = w_r_neg ? (~w_div_r + 1'b1) : w_div_r;
    end
  end

  // ---------------- datapath / HI-LO next state ----------------
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (op <= OP_MSUBU) begin
            op_d     = op;
            a_d      = a;
            b_d      = b;
            mcand_d  = {{WIDTH{1'b0}}, w_a_mag};
            mplier_d = w_b_mag;
            prod_d   = '0;
            cnt_d    = '0;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_commit) begin
          {hi_d, lo_d} = w_mul_result;
          done_d       = 1'b1;
        end else if (!cancel) begin
          prod_d   = prod_q + w_partial;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        if (w_div_commit) begin
          hi_d   = w_div_hi;
          lo_d   = w_div_lo;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mult_div_unit                                           |
// | Purpose : Scoreboard bench for mult_div_unit (WIDTH=32, MUL_STEP=8). |
// |           Directed ops push hand-computed {hi,lo} results; a monitor |
// |           pops and compares on every done pulse.                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int C_MUL = 5;
  localparam int C_DIV = 33;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .MUL_STEP(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h_%h expected=no_done", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        chk64("result", {hi, lo}, mon_exp);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic op_run(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int cyc,
                        input bit intrude);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(exp);
    @(negedge clk) chk1({name, "_busy_issue"}, busy, 1'b1);
    @(posedge clk) #1;
    start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0F0F_F0F0;
    for (int i = 1; i <= cyc; i++) begin
      if (intrude && i == 3) begin
        start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
      end
      @(negedge clk);
      chk1({name, "_busy_run"}, busy, 1'b1);
      chk1({name, "_done_early"}, done, 1'b0);
      @(posedge clk) #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk1({name, "_busy_after"}, busy, 1'b0);
    chk1({name, "_done_pulse"}, done, 1'b1);
    @(posedge clk) #1;
    @(negedge clk) chk1({name, "_done_once"}, done, 1'b0);
    @(posedge clk) #1;
  endtask

  task automatic op_mt(input string name, input logic [3:0] o, input logic [31:0] x,
                       input logic [63:0] exp_hilo);
    start = 1'b1; op = o; a = x;
    @(negedge clk) chk1({name, "_busy"}, busy, 1'b0);
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    chk64({name, "_hilo"}, {hi, lo}, exp_hilo);
    chk1({name, "_no_done"}, done, 1'b0);
    @(posedge clk) #1;
  endtask

  task automatic op_cancel(input string name, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int k, input logic [63:0] exp_hilo);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (k - 1) @(posedge clk) #1;
    cancel = 1'b1;
    @(negedge clk) chk1({name, "_busy_before"}, busy, 1'b1);
    @(posedge clk) #1;
    cancel = 1'b0;
    @(negedge clk);
    chk1({name, "_busy_after"}, busy, 1'b0);
    chk1({name, "_no_done"}, done, 1'b0);
    chk64({name, "_hilo_kept"}, {hi, lo}, exp_hilo);
    @(posedge clk) #1;
  endtask

  task automatic op_ignored(input string name, input logic [3:0] o, input logic [31:0] x,
                            input logic canc, input logic [63:0] exp_hilo);
    start = 1'b1; op = o; a = x; b = x; cancel = canc;
    @(negedge clk) chk1({name, "_busy"}, busy, 1'b0);
    @(posedge clk) #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk1({name, "_busy_after"}, busy, 1'b0);
    chk64({name, "_hilo_kept"}, {hi, lo}, exp_hilo);
    @(posedge clk) #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk64("reset_hilo", {hi, lo}, 64'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    @(posedge clk) #1;

    op_run("mult_neg",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA, C_MUL, 1'b0);
    op_run("divu",      OP_DIVU,  32'd100,       32'd7,        64'h00000002_0000000E, C_DIV, 1'b0);
    op_run("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, C_DIV, 1'b0);
    op_run("div_zero",  OP_DIV,   32'h0000_1234, 32'd0,        64'h00001234_FFFFFFFF, C_DIV, 1'b0);
    op_run("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, C_DIV, 1'b0);
    op_run("divu_zero", OP_DIVU,  32'd5,         32'd0,        64'h00000005_FFFFFFFF, C_DIV, 1'b0);

    // Reset in the middle of a multiply: nothing commits.
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
    @(posedge clk) #1;
    start = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    chk64("midreset_hilo", {hi, lo}, 64'h0);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_done", done, 1'b0);
    @(posedge clk) #1;

    op_mt("mthi", OP_MTHI, 32'h0000_0000, 64'h00000000_00000000);
    op_mt("mtlo", OP_MTLO, 32'hFFFF_FFFF, 64'h00000000_FFFFFFFF);
    op_run("maddu", OP_MADDU, 32'd1, 32'd1, 64'h00000001_00000000, C_MUL, 1'b0);
    op_run("msub",  OP_MSUB,  32'd2, 32'd1, 64'h00000000_FFFFFFFE, C_MUL, 1'b0);

    op_cancel("cancel_div", OP_DIVU, 32'd100, 32'd7, 10, 64'h00000000_FFFFFFFE);
    op_run("multu_after_cancel", OP_MULTU, 32'd3, 32'd4, 64'h00000000_0000000C, C_MUL, 1'b0);
    op_cancel("cancel_commit", OP_MULT, 32'd7, 32'd9, C_MUL, 64'h00000000_0000000C);
    op_ignored("reserved_op", 4'd12, 32'h1111_2222, 1'b0, 64'h00000000_0000000C);
    op_ignored("mthi_cancel", OP_MTHI, 32'h0000_DEAD, 1'b1, 64'h00000000_0000000C);

    op_run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, C_MUL, 1'b0);
    op_run("msubu",     OP_MSUBU, 32'd2,         32'd3,         64'hFFFFFFFD_FFFFFFFB, C_MUL, 1'b0);
    op_run("madd_negs", OP_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFD_FFFFFFFC, C_MUL, 1'b0);
    op_run("divu_intrude", OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, C_DIV, 1'b1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk64("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
